// File: rtl/cpu_controller.sv
// VeriRISC eight-phase instruction sequencer: decodes phase, opcode and zero
// into the datapath strobes; one instruction per eight clocks, HLT freezes it.
module cpu_controller #(
   parameter int unsigned OPCODE_WIDTH = 3,
   parameter int unsigned PHASE_WIDTH  = 3
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [OPCODE_WIDTH-1:0] opcode,
   input  logic                    zero,
   output logic                    sel,
   output logic                    rd,
   output logic                    ld_ir,
   output logic                    inc_pc,
   output logic                    ld_pc,
   output logic                    ld_ac,
   output logic                    wr,
   output logic                    data_e,
   output logic                    halt,
   output logic [PHASE_WIDTH-1:0]  phase
);

   localparam logic [OPCODE_WIDTH-1:0] OP_HLT = OPCODE_WIDTH'(0);
   localparam logic [OPCODE_WIDTH-1:0] OP_SKZ = OPCODE_WIDTH'(1);
   localparam logic [OPCODE_WIDTH-1:0] OP_ADD = OPCODE_WIDTH'(2);
   localparam logic [OPCODE_WIDTH-1:0] OP_AND = OPCODE_WIDTH'(3);
   localparam logic [OPCODE_WIDTH-1:0] OP_XOR = OPCODE_WIDTH'(4);
   localparam logic [OPCODE_WIDTH-1:0] OP_LDA = OPCODE_WIDTH'(5);
   localparam logic [OPCODE_WIDTH-1:0] OP_STO = OPCODE_WIDTH'(6);
   localparam logic [OPCODE_WIDTH-1:0] OP_JMP = OPCODE_WIDTH'(7);

   typedef enum logic [PHASE_WIDTH-1:0] {
      PH_INST_ADDR  = PHASE_WIDTH'(0),
      PH_INST_FETCH = PHASE_WIDTH'(1),
      PH_INST_LOAD  = PHASE_WIDTH'(2),
      PH_IDLE       = PHASE_WIDTH'(3),
      PH_OP_ADDR    = PHASE_WIDTH'(4),
      PH_OP_FETCH   = PHASE_WIDTH'(5),
      PH_ALU_OP     = PHASE_WIDTH'(6),
      PH_STORE      = PHASE_WIDTH'(7)
   } phase_e;

   phase_e phase_q, phase_d;
   logic   halted_q, halted_d;
   logic   alu_op_c;
   logic   hlt_now_c;

   assign alu_op_c  = opcode inside {OP_ADD, OP_AND, OP_XOR, OP_LDA};
   assign hlt_now_c = (phase_q == PH_OP_ADDR) && (opcode == OP_HLT);

   // Next phase: advance by one and wrap, except when halting or halted.
   always_comb begin
      phase_d  = phase_e'(phase_q + PHASE_WIDTH'(1));
      halted_d = halted_q;
      if (halted_q) begin
         phase_d = phase_q;
      end else if (hlt_now_c) begin
         phase_d  = phase_q;
         halted_d = 1'b1;
      end
   end

   // Phase and halted flag; reset aborts any in-flight instruction.
   always_ff @(posedge clk) begin
      if (rst) begin
         phase_q  <= PH_INST_ADDR;
         halted_q <= 1'b0;
      end else begin
         phase_q  <= phase_d;
         halted_q <= halted_d;
      end
   end

   // Strobe decode; reset masks everything so a mid-op abort takes effect at once.
   always_comb begin
      sel    = 1'b0;
      rd     = 1'b0;
      ld_ir  = 1'b0;
      inc_pc = 1'b0;
      ld_pc  = 1'b0;
      ld_ac  = 1'b0;
      wr     = 1'b0;
      data_e = 1'b0;
      halt   = 1'b0;
      phase  = phase_q;
      if (rst) begin
         phase = '0;
      end else if (halted_q) begin
         halt = 1'b1;
      end else begin
         case (phase_q)
            PH_INST_ADDR: begin
               sel = 1'b1;
            end
            PH_INST_FETCH: begin
               sel = 1'b1;
               rd  = 1'b1;
            end
            PH_INST_LOAD, PH_IDLE: begin
               sel   = 1'b1;
               rd    = 1'b1;
               ld_ir = 1'b1;
            end
            PH_OP_ADDR: begin
               inc_pc = 1'b1;
               halt   = (opcode == OP_HLT);
            end
            PH_OP_FETCH: begin
               rd = alu_op_c;
            end
            PH_ALU_OP: begin
               rd     = alu_op_c;
               inc_pc = (opcode == OP_SKZ) && zero;
               ld_pc  = (opcode == OP_JMP);
               data_e = (opcode == OP_STO);
            end
            PH_STORE: begin
               rd     = alu_op_c;
               ld_ac  = alu_op_c;
               ld_pc  = (opcode == OP_JMP);
               inc_pc = (opcode == OP_JMP);
               wr     = (opcode == OP_STO);
               data_e = (opcode == OP_STO);
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_cpu_controller.sv
// Scoreboard bench for cpu_controller: the stimulus process pushes hand-computed
// expectations, a negedge monitor pops and compares against the live outputs.
module tb_cpu_controller;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [2:0] opcode = 3'd2;
   logic       zero = 1'b0;
   logic       sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt;
   logic [2:0] phase;

   // Strobe bit weights: sel 100 rd 080 ld_ir 040 inc_pc 020 ld_pc 010
   // ld_ac 008 wr 004 data_e 002 halt 001; expectation = {phase, strobes}.
   logic [11:0] exp_q[$];
   string       tag_q[$];
   int          n_checks = 0;
   int          n_pass   = 0;

   // Per-phase expected strobes, packed {ph7,...,ph0}.
   localparam logic [71:0] SEQ_ADD  = {9'h088, 9'h080, 9'h080, 9'h020, 9'h1C0, 9'h1C0, 9'h180, 9'h100};
   localparam logic [71:0] SEQ_SKZ1 = {9'h000, 9'h020, 9'h000, 9'h020, 9'h1C0, 9'h1C0, 9'h180, 9'h100};
   localparam logic [71:0] SEQ_SKZ0 = {9'h000, 9'h000, 9'h000, 9'h020, 9'h1C0, 9'h1C0, 9'h180, 9'h100};
   localparam logic [71:0] SEQ_JMP  = {9'h030, 9'h010, 9'h000, 9'h020, 9'h1C0, 9'h1C0, 9'h180, 9'h100};
   localparam logic [71:0] SEQ_STO  = {9'h006, 9'h002, 9'h000, 9'h020, 9'h1C0, 9'h1C0, 9'h180, 9'h100};
   localparam logic [71:0] SEQ_HLT  = {9'h000, 9'h000, 9'h000, 9'h021, 9'h1C0, 9'h1C0, 9'h180, 9'h100};

   cpu_controller #(.OPCODE_WIDTH(3), .PHASE_WIDTH(3)) dut (
      .clk   (clk),
      .rst   (rst),
      .opcode(opcode),
      .zero  (zero),
      .sel   (sel),
      .rd    (rd),
      .ld_ir (ld_ir),
      .inc_pc(inc_pc),
      .ld_pc (ld_pc),
      .ld_ac (ld_ac),
      .wr    (wr),
      .data_e(data_e),
      .halt  (halt),
      .phase (phase)
   );

   always #5 clk = ~clk;

   // One cycle of stimulus: drive just after the edge, queue the expectation.
   task automatic step(input logic r, input logic [2:0] op, input logic z,
                       input logic [2:0] ph, input logic [8:0] s, input string tag);
      @(posedge clk);
      #1;
      rst    = r;
      opcode = op;
      zero   = z;
      exp_q.push_back({ph, s});
      tag_q.push_back(tag);
   endtask

   // Phases first..last of one instruction, zero driven per phase from zmask.
   task automatic run_instr(input logic [2:0] op, input logic [7:0] zmask,
                            input logic [71:0] seq, input int first, input int last,
                            input string tag);
      for (int p = first; p <= last; p++) begin
         step(1'b0, op, zmask[p], 3'(p), seq[p*9 +: 9], $sformatf("%s_ph%0d", tag, p));
      end
   endtask

   // Monitor: the controller presents outputs every cycle; check at negedge.
   initial begin : monitor
      logic [11:0] e, a;
      string       t;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            a = {phase, sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt};
            n_checks++;
            if (a === e) n_pass++;
            else $display("FAIL %s: got phase=%0d strobes=%03h, want phase=%0d strobes=%03h",
                          t, a[11:9], a[8:0], e[11:9], e[8:0]);
         end
      end
   end

   initial begin : stimulus
      int budget;
      // Reset held two clocks: everything quiet, phase 0.
      step(1'b1, 3'd2, 1'b1, 3'd0, 9'h000, "rst_a");
      step(1'b1, 3'd2, 1'b1, 3'd0, 9'h000, "rst_b");
      run_instr(3'd2, 8'h00, SEQ_ADD, 0, 7, "add");
      step(1'b0, 3'd2, 1'b0, 3'd0, 9'h100, "wrap_ph0");
      run_instr(3'd5, 8'hFF, SEQ_ADD, 1, 7, "lda");
      run_instr(3'd1, 8'h40, SEQ_SKZ1, 0, 7, "skz_z1");
      run_instr(3'd1, 8'h00, SEQ_SKZ0, 0, 7, "skz_z0");
      run_instr(3'd1, 8'h20, SEQ_SKZ0, 0, 7, "skz_z_ph5");
      run_instr(3'd7, 8'h00, SEQ_JMP, 0, 7, "jmp");
      run_instr(3'd6, 8'h00, SEQ_STO, 0, 7, "sto");
      // Halt then hold with a different opcode.
      run_instr(3'd0, 8'h00, SEQ_HLT, 0, 4, "hlt");
      for (int i = 0; i < 20; i++) begin
         step(1'b0, 3'd2, i[0], 3'd4, 9'h001, $sformatf("halted_%0d", i));
      end
      step(1'b1, 3'd2, 1'b0, 3'd0, 9'h000, "hlt_rst");
      run_instr(3'd2, 8'h00, SEQ_ADD, 0, 7, "add_after_hlt");
      // Mid-op abort during a jump's ALU_OP phase.
      run_instr(3'd7, 8'h00, SEQ_JMP, 0, 5, "jmp_pre");
      step(1'b1, 3'd7, 1'b0, 3'd0, 9'h000, "midop_rst");
      run_instr(3'd7, 8'h00, SEQ_JMP, 0, 7, "jmp_post");
      // Drain the scoreboard, bounded.
      budget = 0;
      while (exp_q.size() > 0 && budget < 10) begin
         @(posedge clk);
         budget++;
      end
      if (exp_q.size() > 0) begin
         n_checks++;
         $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/cpu_controller.md
Name: cpu_controller

Overview:
- Eight-phase instruction sequencer for the VeriRISC CPU.
- Takes the IR opcode and the ALU zero flag.
- Produces every datapath strobe: memory select/read/write, IR load, PC load/increment, accumulator load, data-bus enable, halt.
- Sits between the instruction register and the ALU/accumulator/PC/memory; one instruction completes per 8 clocks.

Parameters:
- OPCODE_WIDTH, 3, width of opcode input; fixed encoding below requires 3.
- PHASE_WIDTH, 3, width of phase counter and debug phase output.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- opcode  input  OPCODE_WIDTH  current IR opcode (HLT=0, SKZ=1, ADD=2, AND=3, XOR=4, LDA=5, STO=6, JMP=7; same values as ALU opcode)
- zero  input  1  ALU accumulator-is-zero flag
- sel  output  1  1: memory address from PC; 0: from IR operand
- rd  output  1  memory read enable
- ld_ir  output  1  load instruction register
- inc_pc  output  1  increment program counter
- ld_pc  output  1  load PC from IR operand
- ld_ac  output  1  load accumulator from ALU output
- wr  output  1  memory write strobe
- data_e  output  1  drive accumulator onto data bus
- halt  output  1  CPU halted
- phase  output  PHASE_WIDTH  current phase (debug/verification)

Behaviour:
- Phase register: 0 INST_ADDR, 1 INST_FETCH, 2 INST_LOAD, 3 IDLE, 4 OP_ADDR, 5 OP_FETCH, 6 ALU_OP, 7 STORE; plus internal HALTED flag.
- Phase advances by +1 every clock; 7 wraps to 0.
- rst=1 at a clock edge: phase<=0, HALTED<=0, regardless of current phase (mid-instruction abort).
- While rst=1: all strobe outputs forced 0; phase output reads 0.
- Outputs are a combinational decode of phase, opcode and zero; no extra latency.
- ALUOP = opcode in {ADD, AND, XOR, LDA}.
- Phase decode:
  - INST_ADDR: sel=1.
  - INST_FETCH: sel=1, rd=1.
  - INST_LOAD: sel=1, rd=1, ld_ir=1.
  - IDLE: sel=1, rd=1, ld_ir=1.
  - OP_ADDR: inc_pc=1; halt=1 if opcode==HLT.
  - OP_FETCH: rd=ALUOP.
  - ALU_OP: rd=ALUOP; inc_pc=(opcode==SKZ)&zero; ld_pc=(opcode==JMP); data_e=(opcode==STO).
  - STORE: rd=ALUOP; ld_ac=ALUOP; ld_pc=(opcode==JMP); inc_pc=(opcode==JMP); wr=(opcode==STO); data_e=(opcode==STO).
- All unlisted outputs are 0.
- Halt:
  - At the OP_ADDR clock edge with opcode==HLT, HALTED<=1 and phase freezes at 4.
  - While HALTED: halt=1, all other strobes 0, opcode/zero ignored; only rst exits.
- zero is sampled combinationally in ALU_OP only; zero changes in other phases have no effect.
- opcode is assumed stable from IDLE onward; the controller does not latch it.

Test Plan:
- Reset: rst=1 for 2 clocks, then release -> during reset all strobes 0, phase=0; first cycle after release sel=1 only; phase counts 0..7, 0.
- ADD (opcode=2): run 8 clocks -> phase 2/3 ld_ir=1; phase 4 inc_pc=1, halt=0; phases 5-7 rd=1; phase 7 ld_ac=1; wr/ld_pc never 1.
- SKZ (opcode=1): zero=1 -> phase 6 inc_pc=1. Repeat with zero=0 -> inc_pc=0 in phase 6. zero=1 in phase 5 only -> no skip.
- JMP (opcode=7) -> phase 6 ld_pc=1; phase 7 ld_pc=1 and inc_pc=1; rd=0 in phases 5-7. STO (opcode=6) -> phase 6 data_e=1, wr=0; phase 7 wr=1, data_e=1.
- HLT (opcode=0): at phase 4 -> halt=1, inc_pc=1. After that edge phase stays 4, halt=1, others 0 for 20 clocks with opcode changed to 2. rst=1 -> phase 0, halt=0.
- Mid-op reset: assert rst during phase 6 with opcode=7 -> ld_pc drops to 0 immediately. After the edge phase=0; normal sequence resumes on release.
